// File: rtl/lsu_if.sv
// Bundle of the CPU request/response channel and the data-memory port of the load/store unit.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  // Environment side: CPU issuing requests and memory answering reads.
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wen
  );

  // Controller side.
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_wen
  );
endinterface

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller: one access at a time, sub-word stores done as
// read-modify-write on a word-wide memory with combinational read data.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 256
) (
  input logic clk,
  input logic rst_n,
  lsu_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic        we;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] merged;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  always_comb begin
    req_err = 1'b0;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: req_err = 1'b1;
      3'b001, 3'b101:         req_err = bus.req_addr[0];
      3'b010:                 req_err = (bus.req_addr[1:0] != 2'b00);
      default:                req_err = 1'b0;
    endcase
    if (bus.req_addr >= 32'(MEM_BYTES))
      req_err = 1'b1;
  end

  always_comb begin
    sel_b = bus.mem_rdata[{addr[1:0], 3'b000} +: 8];
    sel_h = bus.mem_rdata[{addr[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  load_val = {{24{sel_b[7]}}, sel_b};
      3'b001:  load_val = {{16{sel_h[15]}}, sel_h};
      3'b100:  load_val = {24'd0, sel_b};
      3'b101:  load_val = {16'd0, sel_h};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_comb begin
    merge_val = bus.mem_rdata;
    if (f3[1:0] == 2'b00)
      merge_val[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else
      merge_val[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we      <= 1'b0;
      f3      <= '0;
      addr    <= '0;
      wdata   <= '0;
      merged  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we      <= bus.req_we;
            f3      <= bus.req_funct3;
            addr    <= bus.req_addr;
            wdata   <= bus.req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
            state   <= req_err ? DONE : ACCESS;
          end
        end
        ACCESS: begin
          if (!we) begin
            rdata_q <= load_val;
            state   <= DONE;
          end else if (f3[1:0] == 2'b10) begin
            state   <= DONE;
          end else begin
            merged  <= merge_val;
            state   <= WRITE;
          end
        end
        WRITE: state <= DONE;
        default: begin
          if (bus.rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            state   <= IDLE;
          end
        end
      endcase
    end
  end

  // Memory strobes are decoded from state so an asynchronous reset removes them at once.
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == DONE);
    bus.rsp_rdata = rdata_q;
    bus.rsp_err   = err_q;
    bus.mem_wen   = ((state == ACCESS) && we && (f3[1:0] == 2'b10)) || (state == WRITE);
    bus.mem_addr  = ((state == ACCESS) || (state == WRITE)) ? {addr[31:2], 2'b00} : '0;
    if (state == WRITE)
      bus.mem_wdata = merged;
    else if (bus.mem_wen)
      bus.mem_wdata = wdata;
    else
      bus.mem_wdata = '0;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus random traffic against a
// byte-array reference of memory and the RV32I load/store rules.
module tb_lsu_ctrl;
  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned WORDS     = MEM_BYTES / 4;
  localparam int unsigned AW        = $clog2(MEM_BYTES);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus ();

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [WORDS];
  logic        init_we = 1'b0;
  logic [AW-3:0] init_idx = '0;
  logic [31:0] init_data = '0;

  assign bus.mem_rdata = mem[bus.mem_addr[AW-1:2]];

  always_ff @(posedge clk) begin
    if (init_we)
      mem[init_idx] <= init_data;
    else if (bus.mem_wen)
      mem[bus.mem_addr[AW-1:2]] <= bus.mem_wdata;
  end

  logic [7:0]  rb [MEM_BYTES];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned idx);
    return {rb[4*idx+3], rb[4*idx+2], rb[4*idx+1], rb[4*idx]};
  endfunction

  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int unsigned hold);
    int unsigned sz, lat, wen_cnt, exp_lat, widx;
    logic        err;
    logic [31:0] exp_rd, r_hold;
    sz  = acc_size(f3);
    err = (sz == 0) || (a >= 32'(MEM_BYTES)) || ((a % sz) != 0);
    exp_rd = '0;
    if (!err && !we) begin
      for (int unsigned i = 0; i < sz; i++)
        exp_rd = exp_rd + (32'(rb[a + i]) << (8 * i));
      if (f3 == 3'd0 && exp_rd >= 32'd128)   exp_rd = exp_rd - 32'd256;
      if (f3 == 3'd1 && exp_rd >= 32'd32768) exp_rd = exp_rd - 32'd65536;
    end
    if (err)          exp_lat = 1;
    else if (!we)     exp_lat = 2;
    else if (sz == 4) exp_lat = 2;
    else              exp_lat = 3;

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    lat = 1;
    wen_cnt = 0;
    while (!bus.rsp_valid && lat < 10) begin
      if (bus.mem_wen) begin
        wen_cnt++;
        check("mem_addr", bus.mem_addr, {a[31:2], 2'b00});
      end else begin
        check("mem_wdata_idle", bus.mem_wdata, 32'd0);
      end
      check("req_ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("wen_pulses", wen_cnt, (!err && we) ? 32'd1 : 32'd0);
    check("rsp_err", 32'(bus.rsp_err), 32'(err));
    check("rsp_rdata", bus.rsp_rdata, exp_rd);
    check("mem_wen_done", 32'(bus.mem_wen), 32'd0);
    last_rdata = bus.rsp_rdata;
    r_hold = bus.rsp_rdata;

    if (!err && we)
      for (int unsigned i = 0; i < sz; i++)
        rb[a + i] = 8'(wd >> (8 * i));
    widx = 32'(a[AW-1:2]);
    check("mem_word", mem[widx], ref_word(widx));

    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("hold_rdata", bus.rsp_rdata, r_hold);
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check("back_to_idle", 32'(bus.req_ready), 32'd1);
    check("rsp_valid_clear", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check({tag, "_rsp_err"},   32'(bus.rsp_err), 32'd0);
    check({tag, "_mem_wen"},   32'(bus.mem_wen), 32'd0);
    check({tag, "_mem_addr"},  bus.mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] w, orig;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;

    // Preload memory while held in reset.
    for (int unsigned i = 0; i < WORDS; i++) begin
      w = (i == 4) ? 32'h8899AABB : $urandom;
      for (int unsigned b = 0; b < 4; b++) rb[4*i + b] = 8'(w >> (8 * b));
      @(negedge clk);
      init_we   = 1'b1;
      init_idx  = (AW-2)'(i);
      init_data = w;
    end
    @(negedge clk);
    init_we = 1'b0;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    txn(1'b0, 3'd0, 32'h13, 32'h0, 0);
    check("lb_0x13", last_rdata, 32'hFFFFFF88);
    txn(1'b0, 3'd4, 32'h13, 32'h0, 0);
    check("lbu_0x13", last_rdata, 32'h00000088);
    txn(1'b0, 3'd1, 32'h12, 32'h0, 0);
    check("lh_0x12", last_rdata, 32'hFFFF8899);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("lw_0x10", last_rdata, 32'h8899AABB);
    txn(1'b1, 3'd0, 32'h11, 32'h12345677, 0);
    check("sb_word", mem[4], 32'h889977BB);
    txn(1'b1, 3'd1, 32'h12, 32'h0000CAFE, 0);
    check("sh_word", mem[4], 32'hCAFE77BB);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 5);
    check("lw_hold", last_rdata, 32'hCAFE77BB);
    txn(1'b0, 3'd2, 32'h02, 32'h0, 0);
    txn(1'b0, 3'd3, 32'h20, 32'h0, 0);
    txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1);
    txn(1'b1, 3'd2, 32'hFFFF_FFFC, 32'h1, 0);

    // Reset asserted mid-cycle while the merged SB word is being written.
    orig = mem[4];
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h10;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sb_write_wen", 32'(bus.mem_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_word_kept", mem[4], orig);
    txn(1'b0, 3'd2, 32'h10, 32'h0, 0);
    check("rst_lw", last_rdata, orig);

    for (int unsigned t = 0; t < 80; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'(MEM_BYTES) + $urandom_range(0, 255) : $urandom;
      else
        a = $urandom_range(0, MEM_BYTES - 1);
      txn(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 256: size of the data memory in bytes; any access at or above it is out of range.
REQ-002 clk  input  1  single clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  CPU access request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  CPU accepts the response.
REQ-012 rsp_rdata  output  32  load result, extended; 0 for stores and errors.
REQ-013 rsp_err  output  1  misaligned, illegal funct3, or out-of-range access.
REQ-014 mem_addr  output  32  word-aligned byte address to data memory (bits [1:0] = 0).
REQ-015 mem_wdata  output  32  full word to write.
REQ-016 mem_wen  output  1  write enable; memory writes on the next rising clk edge.
REQ-017 mem_rdata  input  32  combinational read data for mem_addr.

Function
REQ-018 States SHALL be IDLE, ACCESS, WRITE, DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with req_valid && req_ready, latching req_we, req_funct3, req_addr and req_wdata.
REQ-020 Error check at acceptance:
- funct3 in {011, 110, 111}
- H/HU with addr[0] != 0
- W with addr[1:0] != 0
- addr >= MEM_BYTES
On error: next state DONE, rsp_err = 1, rsp_rdata = 0, mem_wen never asserted.
REQ-021 Valid request: IDLE -> ACCESS; mem_addr = {latched addr[31:2], 2'b00} in ACCESS and WRITE, 0 otherwise.
REQ-022 Load in ACCESS: sample mem_rdata, select byte/half by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through; -> DONE.
REQ-023 SW in ACCESS: mem_wen = 1, mem_wdata = latched wdata; -> DONE.
REQ-024 SB/SH in ACCESS: register mem_rdata with the selected byte/half replaced by wdata[7:0] or wdata[15:0]; -> WRITE.
REQ-025 WRITE: mem_wen = 1, mem_wdata = merged word; -> DONE.
REQ-026 mem_wen SHALL be decoded from state only, and SHALL be 0 in IDLE and DONE.
REQ-027 DONE: rsp_valid = 1, with rsp_rdata/rsp_err held stable until rsp_valid && rsp_ready; then -> IDLE.
REQ-028 Latency, counted from the acceptance edge (N):
- rsp_valid at cycle N+2 for loads and SW
- rsp_valid at cycle N+3 for SB/SH
- rsp_valid at cycle N+1 for errors
REQ-029 Back-to-back operation: req_ready rises in the cycle after the response handshake; no request is accepted while in DONE.
REQ-030 mem_wdata SHALL be 0 whenever mem_wen = 0.

Reset
REQ-031 rst_n low SHALL asynchronously force:
- state IDLE
- req_ready = 1
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0
- mem_wen = 0, mem_addr = 0, mem_wdata = 0
REQ-032 Reset during ACCESS or WRITE SHALL drop mem_wen immediately, so no write (partial or merged) reaches memory; the in-flight request is discarded with no response.
REQ-033 The first request is accepted on the first rising edge with rst_n high.

Verification
REQ-034 Memory word 0x10 = 0x8899AABB:
- LB 0x13 -> rsp_rdata 0xFFFFFF88
- LBU 0x13 -> 0x00000088
- LH 0x12 -> 0xFFFF8899
- LW 0x10 -> 0x8899AABB
- each load: rsp_valid at N+2, rsp_err = 0
REQ-035 Stores to word 0x10 = 0x8899AABB:
- SB 0x11, wdata 0x12345677 -> single mem_wen pulse at N+2, word becomes 0x889977BB, rsp at N+3
- SH 0x12, wdata 0x0000CAFE -> word becomes 0xCAFE77BB
REQ-036 Error cases:
- LW 0x02 -> rsp_err = 1, rsp_rdata = 0 at N+1, no mem_wen
- funct3 011 -> rsp_err = 1, no mem_wen
- SW 0x100 with MEM_BYTES = 256 -> rsp_err = 1, no mem_wen
REQ-037 LW with rsp_ready held low 5 cycles: rsp_valid and rsp_rdata stable for all 5 cycles; req_ready = 0 throughout; IDLE one cycle after rsp_ready rises.
REQ-038 SB issued, rst_n low asynchronously mid-cycle in WRITE: mem_wen falls at once and memory word is unchanged; all outputs at reset values; next LW returns the original word.
